// File: rtl/core_pkg.sv
// Shared fetch-stage definitions: PC generator states, instruction size and
// the alignment mask helper used for redirect/trap targets.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int INSTR_BYTES = 4;

  // Low-order PC bits that must be zero for a legal target.
  function automatic logic [1:0] align_mask(input int ialign);
    if (ialign == 16) begin
      return 2'b01;
    end else begin
      return 2'b11;
    end
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot delay, valid/ready fetch offer,
// branch redirect, trap vectoring, misaligned-target reporting and halt/resume.
module pc_gen
  import core_pkg::*;
#(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
  parameter int unsigned         IALIGN       = 32,
  parameter int unsigned         BOOT_CYCLES  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic            halted_o
);

  localparam int              BW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0]   BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [1:0]      AMASK     = align_mask(IALIGN);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [BW-1:0]   boot_cnt_q, boot_cnt_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
  logic            redirect_ok_s;

  assign fetch_valid_o   = (state_q == RUN) && !stall_i;
  assign pc_o            = pc_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;
  assign halted_o        = (state_q == HALT);
  assign redirect_ok_s   = redirect_valid_i && ((redirect_target_i[1:0] & AMASK) == 2'b00);

  // Next-state and next-PC selection in priority order: trap, redirect, sequential advance.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    boot_cnt_d      = boot_cnt_q;
    misalign_d      = 1'b0;
    misalign_addr_d = misalign_addr_q;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + BW'(1);
        end
      end
      RUN, HALT: begin
        if (trap_valid_i) begin
          pc_d = trap_target_i & ~XLEN'(AMASK);
        end else if (redirect_ok_s) begin
          pc_d = redirect_target_i;
        end else if (redirect_valid_i) begin
          misalign_d      = 1'b1;
          misalign_addr_d = redirect_target_i;
        end else if (fetch_valid_o && fetch_ready_i) begin
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end else begin
          pc_d = pc_q;
        end
        // A trap always lands in RUN; halt only takes effect on an otherwise quiet control cycle.
        if (trap_valid_i) begin
          state_d = RUN;
        end else if ((state_q == RUN) && halt_i && !redirect_valid_i) begin
          state_d = HALT;
        end else if ((state_q == HALT) && resume_i) begin
          state_d = RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // All architectural state updates on the clock edge, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= BOOT;
      pc_q            <= RESET_VECTOR;
      boot_cnt_q      <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      boot_cnt_q      <= boot_cnt_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

endmodule
